spi_burst_master: RTL

Parametrised SPI mode-0 master for the on-board accelerometer and similar register-mapped SPI slaves. Runs one complete CS-framed transaction per START: command byte, address byte, then 0..MAX_BYTES full-duplex data bytes, streaming each TX byte in and each RX byte out. Sits between the sensor sequencer (register setup writes, X/Y/Z burst reads) and the board pins, replacing per-operation hardwired SPI logic with a generic command interface.

---
 rtl/spi_burst_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/spi_burst_master.sv
// SPI mode-0 burst master: CS-framed command byte, address byte, then 0..MAX_BYTES full-duplex data bytes.
// Optional build macro SPI_LOOPBACK_EN: sample the master's own MOSI instead of the MISO pin.
module spi_burst_master #(
   parameter int CLK_DIV   = 1221,
   parameter int CS_GAP    = 2442,
   parameter int MAX_BYTES = 8,
   localparam int NW       = $clog2(MAX_BYTES + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          START,
   input  logic [7:0]    CMD,
   input  logic [7:0]    ADDR,
   input  logic [NW-1:0] NBYTES,
   input  logic [7:0]    TX_DATA,
   input  logic          MISO,
   output logic          TX_REQ,
   output logic [NW-1:0] BYTE_IDX,
   output logic [7:0]    RX_DATA,
   output logic          RX_VALID,
   output logic          BUSY,
   output logic          DONE,
   output logic          CS,
   output logic          SCLK,
   output logic          MOSI
);

   localparam int BW = $clog2(16 + 8 * MAX_BYTES + 1);
   localparam int TW = $clog2(((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP) + 1);
   localparam int HW = $clog2(CLK_DIV + 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
   state_t state, state_nxt;

   logic [TW-1:0] tmr;
   logic [HW-1:0] hp_cnt;
   logic          sclk_q;
   logic [15:0]   sr;
   logic [7:0]    rx_sr, rx_data_q;
   logic [BW-1:0] bcnt, last_bit;
   logic [NW-1:0] nbytes_q, byte_idx_q, byte_sel, k_tx, k_rx, nbytes_clamped;
   logic          accept, hp_last, rise, fall, at_boundary, samp;

   // bcnt is the index of the bit currently on the wire; bits 0..15 are the header
   assign hp_last        = (hp_cnt == HW'(CLK_DIV - 1));
   assign rise           = (state == SHIFT) && !sclk_q && hp_last;
   assign fall           = (state == SHIFT) &&  sclk_q && hp_last;
   assign last_bit       = BW'({nbytes_q, 3'b000}) + BW'(15);
   assign byte_sel       = NW'(bcnt >> 3);
   assign k_tx           = byte_sel - NW'(1);
   assign k_rx           = byte_sel - NW'(2);
   assign at_boundary    = fall && (bcnt[2:0] == 3'd7);
   assign nbytes_clamped = (NBYTES > NW'(MAX_BYTES)) ? NW'(MAX_BYTES) : NBYTES;

   assign TX_REQ   = at_boundary && (bcnt >= BW'(15)) && (k_tx < nbytes_q);
   assign RX_VALID = at_boundary && (bcnt >= BW'(23));
   assign BYTE_IDX = TX_REQ ? k_tx : (RX_VALID ? k_rx : byte_idx_q);
   assign RX_DATA  = RX_VALID ? rx_sr : rx_data_q;
   assign CS       = (state == IDLE) || (state == GAP);
   assign SCLK     = sclk_q;
   assign MOSI     = ((state == SETUP) || (state == SHIFT)) ? sr[15] : 1'b0;
   assign BUSY     = (state != IDLE) && !DONE;

`ifdef SPI_LOOPBACK_EN
   assign samp = MOSI;
`else
   assign samp = MISO;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE: begin
            if (START) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: if (tmr == TW'(CLK_DIV - 1)) state_nxt = SHIFT;
         SHIFT: if (fall && (bcnt == last_bit)) state_nxt = HOLD;
         HOLD:  if (tmr == TW'(CLK_DIV - 1)) state_nxt = GAP;
         GAP: begin
            if (tmr == TW'(CS_GAP - 1)) begin
               DONE = 1'b1;
               if (START) begin
                  accept    = 1'b1;
                  state_nxt = SETUP;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         tmr        <= '0;
         hp_cnt     <= '0;
         sclk_q     <= 1'b0;
         sr         <= '0;
         rx_sr      <= '0;
         rx_data_q  <= '0;
         bcnt       <= '0;
         nbytes_q   <= '0;
         byte_idx_q <= '0;
      end else begin
         if ((state_nxt != state) || (state == IDLE) || (state == SHIFT)) tmr <= '0;
         else                                                           tmr <= tmr + TW'(1);

         if ((state == SHIFT) && (state_nxt == SHIFT)) hp_cnt <= hp_last ? '0 : hp_cnt + HW'(1);
         else                                          hp_cnt <= '0;

         if ((state == SHIFT) && hp_last) sclk_q <= ~sclk_q;

         // next data byte is fetched on the same falling edge that shifts it onto MOSI
         if (accept) begin
            sr       <= {CMD, ADDR};
            bcnt     <= '0;
            nbytes_q <= nbytes_clamped;
         end else if (fall) begin
            sr   <= TX_REQ ? {TX_DATA, 8'h00} : {sr[14:0], 1'b0};
            bcnt <= bcnt + BW'(1);
         end

         if (rise)     rx_sr     <= {rx_sr[6:0], samp};
         if (RX_VALID) rx_data_q <= rx_sr;

         if (accept)        byte_idx_q <= '0;
         else if (TX_REQ)   byte_idx_q <= k_tx;
         else if (RX_VALID) byte_idx_q <= k_rx;
      end
   end

endmodule
